// File: rtl/ps2_scancode_ctrl.sv
// PS/2 set-2 scan-code controller: drains the ps2_keyboard FIFO, folds E0/F0 prefixes
// into flags and presents key events over valid/ack. Define PS2_TYPEMATIC_FILTER_EN to drop typematic repeats.
module ps2_scancode_ctrl #(
   parameter int TO_W = 20
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic [7:0] kb_data,
   input  logic       kb_ready,
   input  logic       kb_overflow,
   output logic       kb_rdn,
   output logic [7:0] key_code,
   output logic       key_ext,
   output logic       key_break,
   output logic       key_valid,
   input  logic       key_ack,
   output logic       err_overflow,
   output logic       err_code,
   input  logic       err_clr
);

   typedef enum logic [1:0] {IDLE, READ, DECODE, HOLD} state_t;

   localparam logic [TO_W-1:0] TO_MAX = '1;
   localparam logic [TO_W-1:0] TO_ONE = {{(TO_W-1){1'b0}}, 1'b1};

   state_t          state, state_nxt;
   logic [7:0]      rx_byte;
   logic            pend_ext, pend_brk;
   logic [TO_W-1:0] to_cnt;
   logic            is_ext, is_brk, is_bad, drop_evt;

   assign is_ext = (rx_byte == 8'hE0);
   assign is_brk = (rx_byte == 8'hF0);
   assign is_bad = (rx_byte == 8'h00) || (rx_byte == 8'hFF);

`ifdef PS2_TYPEMATIC_FILTER_EN
   logic [8:0] last_make;
   logic       last_vld;

   // A repeated make of the key already held down is a typematic repeat.
   assign drop_evt = !pend_brk && last_vld && (last_make == {pend_ext, rx_byte});

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         last_make <= '0;
         last_vld  <= 1'b0;
      end else if (state == DECODE && !is_ext && !is_brk && !is_bad) begin
         if (!pend_brk) begin
            if (!drop_evt) begin
               last_make <= {pend_ext, rx_byte};
               last_vld  <= 1'b1;
            end
         end else if (last_make == {pend_ext, rx_byte}) begin
            last_vld <= 1'b0;
         end
      end
   end
`else
   assign drop_evt = 1'b0;
`endif

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) state <= IDLE;
      else       state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      kb_rdn    = 1'b1;
      case (state)
         IDLE:    if (kb_ready) state_nxt = READ;
         READ: begin
            kb_rdn    = 1'b0;
            state_nxt = DECODE;
         end
         DECODE:  state_nxt = (is_ext || is_brk || is_bad || drop_evt) ? IDLE : HOLD;
         HOLD:    if (key_ack) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         rx_byte   <= '0;
         pend_ext  <= 1'b0;
         pend_brk  <= 1'b0;
         to_cnt    <= '0;
         key_code  <= '0;
         key_ext   <= 1'b0;
         key_break <= 1'b0;
         key_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // Pending prefix ages only while waiting; the counter saturates at TO_MAX.
               if (!kb_ready && (pend_ext || pend_brk)) begin
                  if (to_cnt == TO_MAX) begin
                     pend_ext <= 1'b0;
                     pend_brk <= 1'b0;
                  end else begin
                     to_cnt <= to_cnt + TO_ONE;
                  end
               end
            end
            READ: begin
               rx_byte <= kb_data;
               to_cnt  <= '0;
            end
            DECODE: begin
               if (is_ext) begin
                  pend_ext <= 1'b1;
               end else if (is_brk) begin
                  pend_brk <= 1'b1;
               end else begin
                  pend_ext <= 1'b0;
                  pend_brk <= 1'b0;
                  if (!is_bad && !drop_evt) begin
                     key_code  <= rx_byte;
                     key_ext   <= pend_ext;
                     key_break <= pend_brk;
                     key_valid <= 1'b1;
                  end
               end
            end
            HOLD: if (key_ack) key_valid <= 1'b0;
            default: ;
         endcase
      end
   end

   // Sticky error flags: a set in the same cycle as err_clr wins.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         err_overflow <= 1'b0;
         err_code     <= 1'b0;
      end else begin
         err_overflow <= kb_overflow | (err_overflow & ~err_clr);
         err_code     <= ((state == DECODE) && is_bad) | (err_code & ~err_clr);
      end
   end

endmodule

// File: tb/tb_ps2_scancode_ctrl.sv
// Self-checking bench for ps2_scancode_ctrl: vector table, hand sequences, and a
// randomized byte stream compared against a stream-level reference model.
module tb_ps2_scancode_ctrl;

   logic       clk = 1'b0;
   logic       clrn;
   logic [7:0] kb_data;
   logic       kb_ready;
   logic       kb_overflow;
   logic       kb_rdn;
   logic [7:0] key_code;
   logic       key_ext;
   logic       key_break;
   logic       key_valid;
   logic       key_ack;
   logic       err_overflow;
   logic       err_code;
   logic       err_clr;

   ps2_scancode_ctrl #(.TO_W(4)) dut (
      .clk          (clk),
      .clrn         (clrn),
      .kb_data      (kb_data),
      .kb_ready     (kb_ready),
      .kb_overflow  (kb_overflow),
      .kb_rdn       (kb_rdn),
      .key_code     (key_code),
      .key_ext      (key_ext),
      .key_break    (key_break),
      .key_valid    (key_valid),
      .key_ack      (key_ack),
      .err_overflow (err_overflow),
      .err_code     (err_code),
      .err_clr      (err_clr)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int rd_cnt   = 0;

   logic [7:0] fifo_q[$];
   logic [9:0] obs_q[$];   // {ext, brk, code}
   logic [9:0] exp_q[$];
   logic [7:0] rs_q[$];
   bit         model_err;

   typedef struct packed {
      logic [1:0]  n;
      logic [23:0] bytes;
      logic        ev;
      logic [9:0]  evt;
      logic        err;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive_fifo();
      kb_ready = (fifo_q.size() != 0);
      kb_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
   endtask

   task automatic push(input logic [7:0] b);
      fifo_q.push_back(b);
      drive_fifo();
   endtask

   // One clock: sample before the edge, advance, then settle #1 after it.
   task automatic tick();
      bit was_rd;
      was_rd = (kb_rdn === 1'b0);
      if (was_rd) rd_cnt++;
      if (key_valid === 1'b1 && key_ack === 1'b1)
         obs_q.push_back({key_ext, key_break, key_code});
      @(posedge clk);
      #1;
      if (was_rd && fifo_q.size() > 0) fifo_q.delete(0);
      drive_fifo();
   endtask

   task automatic do_reset();
      clrn        = 1'b0;
      key_ack     = 1'b0;
      err_clr     = 1'b0;
      kb_overflow = 1'b0;
      fifo_q.delete();
      obs_q.delete();
      drive_fifo();
      repeat (2) @(posedge clk);
      #1;
      clrn = 1'b1;
   endtask

   // Reference: apply the prefix/event rules directly to the byte stream.
   task automatic run_model();
      bit         pe, pb, lv, keep;
      logic [8:0] lm;
      pe = 0; pb = 0; lv = 0; lm = '0;
      model_err = 0;
      exp_q.delete();
      foreach (rs_q[i]) begin
         if (rs_q[i] == 8'hE0) pe = 1;
         else if (rs_q[i] == 8'hF0) pb = 1;
         else if (rs_q[i] == 8'h00 || rs_q[i] == 8'hFF) begin
            model_err = 1; pe = 0; pb = 0;
         end else begin
            keep = 1;
`ifdef PS2_TYPEMATIC_FILTER_EN
            if (!pb) begin
               if (lv && lm == {pe, rs_q[i]}) keep = 0;
               else begin lm = {pe, rs_q[i]}; lv = 1; end
            end else if (lm == {pe, rs_q[i]}) lv = 0;
`endif
            if (keep) exp_q.push_back({pe, pb, rs_q[i]});
            pe = 0; pb = 0;
         end
      end
   endtask

   function automatic vec_t mk(input logic [1:0] n, input logic [23:0] b, input logic ev,
                               input logic [9:0] evt, input logic err);
      vec_t v;
      v.n = n; v.bytes = b; v.ev = ev; v.evt = evt; v.err = err;
      return v;
   endfunction

   initial begin
      logic [9:0] typ_exp[$];
      bit         stable_ok, got_rd;
      int         n_rand, idx, cyc;
      int         r;

      vecs[0] = mk(2'd1, 24'h1C0000, 1'b1, 10'h01C, 1'b0);
      vecs[1] = mk(2'd2, 24'hF01C00, 1'b1, 10'h11C, 1'b0);
      vecs[2] = mk(2'd3, 24'hE0F075, 1'b1, 10'h375, 1'b0);
      vecs[3] = mk(2'd3, 24'hF0E075, 1'b1, 10'h375, 1'b0);
      vecs[4] = mk(2'd2, 24'hE07500, 1'b1, 10'h275, 1'b0);
      vecs[5] = mk(2'd1, 24'h750000, 1'b1, 10'h075, 1'b0);
      vecs[6] = mk(2'd2, 24'hE0FF00, 1'b0, 10'h000, 1'b1);
      vecs[7] = mk(2'd1, 24'h1C0000, 1'b1, 10'h01C, 1'b0);
      vecs[8] = mk(2'd1, 24'h000000, 1'b0, 10'h000, 1'b1);

      // Reset state
      do_reset();
      check("rst_kb_rdn",    32'(kb_rdn), 32'd1);
      check("rst_key_valid", 32'(key_valid), 32'd0);
      check("rst_key_code",  32'(key_code), 32'd0);
      check("rst_ext_brk",   32'({key_ext, key_break}), 32'd0);
      check("rst_errs",      32'({err_overflow, err_code}), 32'd0);

      // Latency: kb_ready in cycle N -> rdn low N+1, valid N+3
      key_ack = 1'b1;
      rd_cnt  = 0;
      push(8'h1C);
      tick();
      check("lat_rdn_n1", 32'(kb_rdn), 32'd0);
      tick();
      check("lat_rdn_n2", 32'(kb_rdn), 32'd1);
      check("lat_valid_n2", 32'(key_valid), 32'd0);
      tick();
      check("lat_valid_n3", 32'(key_valid), 32'd1);
      check("lat_event", 32'({key_ext, key_break, key_code}), 32'h01C);
      tick();
      check("lat_valid_cleared", 32'(key_valid), 32'd0);
      check("lat_rdn_cycles", 32'(rd_cnt), 32'd1);

      // Vector table
      do_reset();
      key_ack = 1'b1;
      for (int v = 0; v < 9; v++) begin
         err_clr = 1'b1; tick(); err_clr = 1'b0;
         obs_q.delete();
         for (int k = 0; k < int'(vecs[v].n); k++)
            push(vecs[v].bytes[23-8*k -: 8]);
         repeat (30) tick();
         check($sformatf("vec%0d_count", v), 32'(obs_q.size()), 32'(vecs[v].ev));
         if (vecs[v].ev && obs_q.size() > 0)
            check($sformatf("vec%0d_event", v), 32'(obs_q[0]), 32'(vecs[v].evt));
         check($sformatf("vec%0d_err_code", v), 32'(err_code), 32'(vecs[v].err));
      end

      // Backpressure: held event blocks further FIFO reads
      obs_q.delete();
      key_ack = 1'b0;
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      for (int k = 0; k < 20 && key_valid !== 1'b1; k++) tick();
      check("bp_valid", 32'(key_valid), 32'd1);
      stable_ok = 1;
      for (int k = 0; k < 50; k++) begin
         tick();
         if (kb_rdn !== 1'b1 || key_code !== 8'h11 || key_valid !== 1'b1 || fifo_q.size() != 3)
            stable_ok = 0;
      end
      check("bp_stable", 32'(stable_ok), 32'd1);
      key_ack = 1'b1; tick(); key_ack = 1'b0;
      got_rd = 0;
      for (int k = 0; k < 10 && !got_rd; k++) begin
         if (kb_rdn === 1'b0) got_rd = 1;
         else tick();
      end
      check("bp_read_after_ack", 32'(got_rd), 32'd1);
      key_ack = 1'b1;
      repeat (30) tick();
      check("bp_count", 32'(obs_q.size()), 32'd4);
      if (obs_q.size() == 4) begin
         check("bp_ev0", 32'(obs_q[0]), 32'h011);
         check("bp_ev3", 32'(obs_q[3]), 32'h044);
      end

      // Error flags
      obs_q.delete();
      push(8'hFF);
      repeat (8) tick();
      kb_overflow = 1'b1; tick(); kb_overflow = 1'b0; tick();
      check("err_code_set", 32'(err_code), 32'd1);
      check("err_ovf_set", 32'(err_overflow), 32'd1);
      check("err_no_event", 32'(obs_q.size()), 32'd0);
      err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
      check("err_cleared", 32'({err_overflow, err_code}), 32'd0);
      kb_overflow = 1'b1; err_clr = 1'b1; tick();
      kb_overflow = 1'b0; err_clr = 1'b0; tick();
      check("err_set_wins", 32'(err_overflow), 32'd1);

      // Prefix timeout (TO_W=4): long gap drops E0, short gap keeps it
      obs_q.delete();
      push(8'hE0);
      repeat (25) tick();
      push(8'h1C);
      repeat (10) tick();
      check("to_long_count", 32'(obs_q.size()), 32'd1);
      if (obs_q.size() > 0) check("to_long_event", 32'(obs_q[0]), 32'h01C);
      obs_q.delete();
      push(8'hE0);
      repeat (3) tick();
      push(8'h1C);
      repeat (10) tick();
      check("to_short_count", 32'(obs_q.size()), 32'd1);
      if (obs_q.size() > 0) check("to_short_event", 32'(obs_q[0]), 32'h21C);

      // Typematic stream
      do_reset();
      key_ack = 1'b1;
      push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C); push(8'h1C);
      repeat (50) tick();
`ifdef PS2_TYPEMATIC_FILTER_EN
      typ_exp = '{10'h01C, 10'h11C, 10'h01C};
`else
      typ_exp = '{10'h01C, 10'h01C, 10'h01C, 10'h11C, 10'h01C};
`endif
      check("typ_count", 32'(obs_q.size()), 32'(typ_exp.size()));
      for (int i = 0; i < typ_exp.size() && i < obs_q.size(); i++)
         check($sformatf("typ_ev%0d", i), 32'(obs_q[i]), 32'(typ_exp[i]));

      // Randomized stream against the reference model
      do_reset();
      n_rand = 400;
      rs_q.delete();
      for (int i = 0; i < n_rand; i++) begin
         r = $urandom_range(0, 15);
         if (r < 2)       rs_q.push_back(8'hE0);
         else if (r < 4)  rs_q.push_back(8'hF0);
         else if (r == 4) rs_q.push_back(($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00);
         else if (r < 10) rs_q.push_back((r < 7) ? 8'h1C : ((r < 9) ? 8'h75 : 8'h23));
         else             rs_q.push_back(8'($urandom_range(1, 254)));
      end
      run_model();
      idx = 0;
      cyc = 0;
      while (cyc < 20000 && !(idx == n_rand && fifo_q.size() == 0 && obs_q.size() >= exp_q.size())) begin
         key_ack = 1'($urandom_range(0, 1));
         if (idx < n_rand && (fifo_q.size() == 0 || $urandom_range(0, 3) == 0)) begin
            push(rs_q[idx]);
            idx++;
         end
         tick();
         cyc++;
      end
      key_ack = 1'b1;
      repeat (10) tick();
      check("rand_count", 32'(obs_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         check($sformatf("rand_ev%0d", i), 32'(obs_q[i]), 32'(exp_q[i]));
      check("rand_err_code", 32'(err_code), 32'(model_err));
      check("rand_err_ovf", 32'(err_overflow), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ps2_scancode_ctrl.md
Name: ps2_scancode_ctrl

Overview:
Controller that drains the ps2_keyboard receive FIFO and turns raw PS/2 set-2 bytes into key events. It issues one-cycle `kb_rdn` read strobes whenever the FIFO is non-empty, folds the E0 (extended) and F0 (break) prefixes into flags, and presents one event at a time to the consumer over a valid/ack handshake. It sits between ps2_keyboard and the CPU or IO-register layer.

Parameters:
TO_W, 20, width of the prefix-timeout counter; a pending prefix is dropped after 2^TO_W-1 clk cycles with no new byte.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
clrn  input  1  reset, asynchronous, active-low.
kb_data  input  8  FIFO head byte from ps2_keyboard; valid while kb_ready=1.
kb_ready  input  1  FIFO non-empty.
kb_overflow  input  1  FIFO overflow flag from ps2_keyboard.
kb_rdn  output  1  active-low read strobe to ps2_keyboard; pops one byte per low cycle.
key_code  output  8  scan code of the current event, prefixes stripped.
key_ext  output  1  event was preceded by E0.
key_break  output  1  1 = key release (F0 seen), 0 = key press.
key_valid  output  1  event available; held until acknowledged.
key_ack  input  1  consumer accepts the event; sampled only while key_valid=1.
err_overflow  output  1  sticky; set when kb_overflow=1 is sampled.
err_code  output  1  sticky; set on a received 0x00 or 0xFF byte.
err_clr  input  1  synchronous clear of both sticky error flags.

Behaviour:
- Reset (clrn=0, asynchronous): state=IDLE, kb_rdn=1, key_code=0, key_ext=0, key_break=0, key_valid=0, err_overflow=0, err_code=0, pending prefix flags cleared, timeout counter=0.
- FSM states: IDLE, READ, DECODE, HOLD.
- IDLE: if kb_ready=1, go to READ. Otherwise stay in IDLE and advance the timeout counter while a prefix is pending.
- READ: kb_rdn=0 for exactly this one cycle. kb_data is captured into the byte register at the end of the cycle. Next state is DECODE. kb_rdn is never low in any other state.
- DECODE (one cycle, kb_rdn=1, which gives the FIFO pointer time to settle):
  - byte=0xE0: set pend_ext; go to IDLE.
  - byte=0xF0: set pend_brk; go to IDLE.
  - byte=0x00 or 0xFF: set err_code; clear both pending flags; go to IDLE; no event.
  - any other byte: load key_code=byte, key_ext=pend_ext, key_break=pend_brk; clear pending flags; set key_valid=1; go to HOLD.
- HOLD: key_valid and the key_* outputs are stable. On key_ack=1, clear key_valid and go to IDLE. The FIFO is not read while in HOLD, so backpressure lands on the ps2_keyboard FIFO.
- Latency: kb_ready rising in cycle N with the FSM in IDLE gives kb_rdn=0 in cycle N+1 and key_valid=1 in cycle N+3. Minimum spacing is 4 cycles per FIFO byte.
- key_ack asserted while key_valid=0 is ignored.
- Timeout: the counter resets on every READ. If it reaches 2^TO_W-1 with a prefix pending, pend_ext and pend_brk are cleared. The counter saturates and does not wrap.
- err_overflow: set on any cycle where kb_overflow=1.
- err_clr=1: clears both sticky flags. A set request in the same cycle wins over the clear.
- Prefix order: E0 F0 xx and F0 E0 xx both yield ext=1, brk=1.

Optional Feature:
PS2_TYPEMATIC_FILTER_EN
- Defined: the block tracks last_make = {ext, code} plus a last_vld bit.
  - A make event equal to last_make while last_vld=1 is discarded: no key_valid, FSM returns to IDLE from DECODE.
  - Any other make event updates last_make and sets last_vld.
  - A break event whose {ext, code} matches last_make clears last_vld.
  - Break events are always emitted.
  - Reset clears last_vld.
- Undefined: every make event is emitted, including typematic repeats.

Test Plan:
- FIFO holds 0x1C, ack held at 1 → kb_rdn low for exactly 1 cycle; key_code=0x1C, ext=0, brk=0; key_valid rises 3 cycles after kb_ready.
- Bytes F0,1C → exactly one event: code=0x1C, brk=1, ext=0. No event is produced for the F0 byte.
- Bytes E0,F0,75 → one event: code=0x75, ext=1, brk=1. A following 0x75 yields ext=0, brk=0, proving the flags cleared.
- Event pending with key_ack=0 for 50 cycles while FIFO holds 3 bytes → kb_rdn stays 1 and outputs stay stable. After the ack pulse, the next byte is read.
- Byte 0xFF then kb_overflow pulse → err_code=1 and err_overflow=1 with no event; err_clr pulse → both return to 0. Also E0 followed by no byte for 2^TO_W cycles (TO_W=4) then 0x1C → ext=0.
- With PS2_TYPEMATIC_FILTER_EN, bytes 1C,1C,1C,F0,1C,1C → events: make 1C, break 1C, make 1C (3 total). Without the macro, the same stream gives 6 bytes → 5 events.
